// File: rtl/hnoc_pkg.sv
// hnoc_pkg: shared constants for the 8-PE hierarchical NoC and the packet destination extractor
package hnoc_pkg;
  localparam int NUM_PE = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int PKT_W = 35;
  function automatic logic [ADDR_W-1:0] pkt_dest(input logic [PKT_W-1:0] pkt);
    return pkt[DATA_W+:ADDR_W];
  endfunction
endpackage

// File: rtl/noc_fifo.sv
// noc_fifo: first-word-fall-through FIFO; write side i_data/i_valid/o_ready, read side o_data/o_valid/i_ready, full/empty from registered occupancy
module noc_fifo #(
  parameter int Width = 35,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [Width-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);
  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic push, pop;
  assign o_ready = cnt_q != CW'(Depth);
  assign o_valid = cnt_q != '0;
  assign o_data = o_valid ? mem_q[rd_ptr_q] : '0;
  assign push = i_valid && o_ready;
  assign pop = o_valid && i_ready;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end
endmodule

// File: rtl/pe_net_if.sv
// pe_net_if: PE-to-router interface; TX FIFO (i_pe_* -> o_net_*), RX skid buffer with destination filter (i_net_* -> o_rx_*), saturating tx/rx/drop counters and sticky o_misroute cleared by i_clr_stats
module pe_net_if import hnoc_pkg::*; #(
  parameter int address = 0,
  parameter int AddressWidth = ADDR_W,
  parameter int DataWidth = DATA_W,
  parameter int TotalWidth = PKT_W,
  parameter int FifoDepth = 4,
  parameter int CntWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TotalWidth-1:0] i_pe_data,
  input  logic                  i_pe_valid,
  output logic                  o_pe_ready,
  output logic [TotalWidth-1:0] o_net_data,
  output logic                  o_net_valid,
  input  logic                  i_net_ready,
  input  logic [TotalWidth-1:0] i_net_data,
  input  logic                  i_net_valid,
  output logic                  o_net_ready,
  output logic [TotalWidth-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  input  logic                  i_clr_stats,
  output logic [CntWidth-1:0]   o_tx_count,
  output logic [CntWidth-1:0]   o_rx_count,
  output logic [CntWidth-1:0]   o_drop_count,
  output logic                  o_misroute
);
  localparam logic [AddressWidth-1:0] MyAddr = AddressWidth'(address % NUM_PE);
  logic match, drop, tx_pop, rx_pop;
  logic [CntWidth-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, drop_cnt_q, drop_cnt_d;
  logic misroute_q, misroute_d;
  function automatic logic [CntWidth-1:0] bump(input logic [CntWidth-1:0] c, input logic inc, input logic clr);
    return clr ? '0 : (inc && c != '1) ? c + CntWidth'(1) : c;
  endfunction
  noc_fifo #(.Width(TotalWidth), .Depth(FifoDepth)) u_tx (
    .clk(clk), .rst(rst),
    .i_data(i_pe_data), .i_valid(i_pe_valid), .o_ready(o_pe_ready),
    .o_data(o_net_data), .o_valid(o_net_valid), .i_ready(i_net_ready)
  );
  // misrouted beats are consumed by the handshake but never written
  noc_fifo #(.Width(TotalWidth), .Depth(2)) u_rx (
    .clk(clk), .rst(rst),
    .i_data(i_net_data), .i_valid(i_net_valid && match), .o_ready(o_net_ready),
    .o_data(o_rx_data), .o_valid(o_rx_valid), .i_ready(i_rx_ready)
  );
  assign match = i_net_data[DataWidth+:AddressWidth] == MyAddr;
  assign drop = i_net_valid && o_net_ready && !match;
  assign tx_pop = o_net_valid && i_net_ready;
  assign rx_pop = o_rx_valid && i_rx_ready;
  always_comb begin
    tx_cnt_d = bump(tx_cnt_q, tx_pop, i_clr_stats);
    rx_cnt_d = bump(rx_cnt_q, rx_pop, i_clr_stats);
    drop_cnt_d = bump(drop_cnt_q, drop, i_clr_stats);
    misroute_d = !i_clr_stats && (misroute_q || drop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      drop_cnt_q <= '0;
      misroute_q <= 1'b0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      misroute_q <= misroute_d;
    end
  end
  assign o_tx_count = tx_cnt_q;
  assign o_rx_count = rx_cnt_q;
  assign o_drop_count = drop_cnt_q;
  assign o_misroute = misroute_q;
endmodule

// File: tb/tb_pe_net_if.sv
// tb_pe_net_if: directed bench for pe_net_if with a queue-based reference model checked every cycle
module tb_pe_net_if;
  import hnoc_pkg::*;
  localparam int ADDR = 2;
  logic clk = 0, rst = 1;
  logic [34:0] i_pe_data = '0, i_net_data = '0;
  logic i_pe_valid = 0, i_net_ready = 0, i_net_valid = 0, i_rx_ready = 0, i_clr_stats = 0;
  logic o_pe_ready, o_net_valid, o_net_ready, o_rx_valid, o_misroute;
  logic [34:0] o_net_data, o_rx_data;
  logic [15:0] o_tx_count, o_rx_count, o_drop_count;
  pe_net_if #(.address(ADDR)) dut (
    .clk(clk), .rst(rst),
    .i_pe_data(i_pe_data), .i_pe_valid(i_pe_valid), .o_pe_ready(o_pe_ready),
    .o_net_data(o_net_data), .o_net_valid(o_net_valid), .i_net_ready(i_net_ready),
    .i_net_data(i_net_data), .i_net_valid(i_net_valid), .o_net_ready(o_net_ready),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
    .i_clr_stats(i_clr_stats),
    .o_tx_count(o_tx_count), .o_rx_count(o_rx_count), .o_drop_count(o_drop_count),
    .o_misroute(o_misroute)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  logic [34:0] txq[$], rxq[$];
  int m_tx = 0, m_rx = 0, m_drop = 0;
  bit m_mis = 0;
  function automatic int sat(input int c, input bit inc);
    return (inc && c < 65535) ? c + 1 : c;
  endfunction
  always @(posedge clk or posedge rst) begin
    bit tpush, tpop, racc, rpop, drp;
    if (rst) begin
      txq.delete();
      rxq.delete();
      m_tx = 0;
      m_rx = 0;
      m_drop = 0;
      m_mis = 0;
    end else begin
      tpush = i_pe_valid && txq.size() < 4;
      tpop = txq.size() > 0 && i_net_ready;
      racc = i_net_valid && rxq.size() < 2;
      rpop = rxq.size() > 0 && i_rx_ready;
      drp = racc && pkt_dest(i_net_data) != 3'(ADDR);
      if (tpop) void'(txq.pop_front());
      if (tpush) txq.push_back(i_pe_data);
      if (rpop) void'(rxq.pop_front());
      if (racc && !drp) rxq.push_back(i_net_data);
      if (i_clr_stats) begin
        m_tx = 0;
        m_rx = 0;
        m_drop = 0;
        m_mis = 0;
      end else begin
        m_tx = sat(m_tx, tpop);
        m_rx = sat(m_rx, rpop);
        m_drop = sat(m_drop, drp);
        m_mis = m_mis | drp;
      end
    end
  end
  always @(negedge clk) begin
    check("pe_ready", o_pe_ready, txq.size() != 4);
    check("net_valid", o_net_valid, txq.size() != 0);
    check("net_data", o_net_data, txq.size() ? txq[0] : 35'd0);
    check("net_ready", o_net_ready, rxq.size() < 2);
    check("rx_valid", o_rx_valid, rxq.size() != 0);
    check("rx_data", o_rx_data, rxq.size() ? rxq[0] : 35'd0);
    check("tx_count", o_tx_count, m_tx);
    check("rx_count", o_rx_count, m_rx);
    check("drop_count", o_drop_count, m_drop);
    check("misroute", o_misroute, m_mis);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_net(input logic [34:0] pkt);
    bit acc;
    bit done = 0;
    i_net_data = pkt;
    i_net_valid = 1;
    for (int k = 0; k < 20 && !done; k++) begin
      acc = o_net_ready;
      tick();
      done = acc;
    end
    if (!done) check("net_accept_timeout", 0, 1);
    i_net_valid = 0;
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    check("rst_pe_ready", o_pe_ready, 1);
    check("rst_net_ready", o_net_ready, 1);
    check("rst_net_valid", o_net_valid, 0);
    check("rst_rx_valid", o_rx_valid, 0);
    check("rst_tx_count", o_tx_count, 0);
    check("rst_misroute", o_misroute, 0);
    i_net_ready = 1;
    i_pe_data = {3'd5, 32'd200};
    i_pe_valid = 1;
    tick();
    i_pe_valid = 0;
    check("send_valid", o_net_valid, 1);
    check("send_data", o_net_data, {3'd5, 32'd200});
    tick();
    check("send_tx_count", o_tx_count, 1);
    i_net_ready = 0;
    for (int k = 0; k < 4; k++) begin
      i_pe_data = 35'(k);
      i_pe_valid = 1;
      tick();
    end
    i_pe_data = 35'd4;
    check("full_pe_ready", o_pe_ready, 0);
    tick();
    tick();
    check("full_head", o_net_data, 35'd0);
    i_net_ready = 1;
    tick();
    check("fullpop_head", o_net_data, 35'd1);
    check("fullpop_pe_ready", o_pe_ready, 1);
    tick();
    i_pe_valid = 0;
    check("fifth_head", o_net_data, 35'd2);
    repeat (3) tick();
    check("drain_valid", o_net_valid, 0);
    check("drain_tx_count", o_tx_count, 6);
    i_rx_ready = 1;
    i_net_valid = 1;
    i_net_data = {3'd2, 32'd10};
    tick();
    check("rx10_valid", o_rx_valid, 1);
    check("rx10_data", o_rx_data, {3'd2, 32'd10});
    i_net_data = {3'd6, 32'd11};
    tick();
    check("drop_rx_valid", o_rx_valid, 0);
    check("drop_misroute", o_misroute, 1);
    check("drop_count", o_drop_count, 1);
    i_net_data = {3'd2, 32'd12};
    tick();
    check("rx12_data", o_rx_data, {3'd2, 32'd12});
    i_net_valid = 0;
    tick();
    check("rx_count2", o_rx_count, 2);
    i_rx_ready = 0;
    send_net({3'd2, 32'd20});
    send_net({3'd2, 32'd21});
    check("stall_net_ready", o_net_ready, 0);
    i_net_data = {3'd2, 32'd22};
    i_net_valid = 1;
    tick();
    tick();
    check("stall_head", o_rx_data, {3'd2, 32'd20});
    i_rx_ready = 1;
    send_net({3'd2, 32'd22});
    send_net({3'd2, 32'd23});
    repeat (4) tick();
    check("stall_rx_count", o_rx_count, 6);
    check("stall_rx_empty", o_rx_valid, 0);
    i_pe_valid = 1;
    for (int k = 0; k < 65530; k++) begin
      i_pe_data = {3'd1, 32'(k)};
      tick();
    end
    i_pe_valid = 0;
    tick();
    tick();
    check("sat_tx_count", o_tx_count, 16'hFFFF);
    i_pe_valid = 1;
    tick();
    i_pe_valid = 0;
    tick();
    tick();
    check("sat_hold", o_tx_count, 16'hFFFF);
    i_clr_stats = 1;
    tick();
    i_clr_stats = 0;
    check("clr_tx", o_tx_count, 0);
    check("clr_rx", o_rx_count, 0);
    check("clr_drop", o_drop_count, 0);
    check("clr_misroute", o_misroute, 0);
    i_net_ready = 0;
    i_pe_valid = 1;
    tick();
    i_pe_valid = 0;
    i_net_ready = 1;
    i_clr_stats = 1;
    tick();
    i_clr_stats = 0;
    check("clr_wins", o_tx_count, 0);
    check("clr_pop_done", o_net_valid, 0);
    i_net_ready = 0;
    i_pe_data = {3'd3, 32'd77};
    i_pe_valid = 1;
    tick();
    i_pe_valid = 0;
    i_rx_ready = 0;
    send_net({3'd2, 32'd30});
    send_net({3'd7, 32'd31});
    check("pre_rst_misroute", o_misroute, 1);
    check("pre_rst_rx_valid", o_rx_valid, 1);
    rst = 1;
    #1;
    check("mid_rst_net_valid", o_net_valid, 0);
    check("mid_rst_rx_valid", o_rx_valid, 0);
    check("mid_rst_net_data", o_net_data, 0);
    check("mid_rst_rx_data", o_rx_data, 0);
    check("mid_rst_drop", o_drop_count, 0);
    check("mid_rst_misroute", o_misroute, 0);
    tick();
    rst = 0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
